trng_collector: RTL

Consumer-side block for the ring-oscillator TRNG's registered raw bit stream. It samples one raw bit per clock and runs a continuous repetition-count health test on the raw bits. Accepted bits are deserialized into W-bit words, which are delivered to the downstream logic (PUF/BIST controller or host interface) over a valid/ready handshake. A health failure is latched and blocks all further output until reset.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/trng_vn_debias.sv | 45 ++++
 rtl/trng_collector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
//   Shared definitions for the TRNG raw-bit collector:
//     - trng_state_e : collector FSM states (ST_IDLE, ST_FILL, ST_FAIL)
//     - TRNG_*       : default values for the collector parameters
// ---------------------------------------------------------------------------
package trng_pkg;

    localparam int TRNG_W        = 32;  // output word width
    localparam int TRNG_LOGW     = 5;   // fill counter width (counts 0..W-1)
    localparam int TRNG_RC_LIMIT = 32;  // identical-bit run length that fails
    localparam int TRNG_LOG_RC   = 6;   // repetition counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FAIL = 2'd2
    } trng_state_e;

endpackage

// File: rtl/trng_vn_debias.sv
// ---------------------------------------------------------------------------
// trng_vn_debias
//   Von Neumann extractor. Raw bits are paired in arrival order; pair 01
//   emits 0, pair 10 emits 1, pairs 00/11 emit nothing. The emitted bit is
//   presented combinationally in the cycle the second bit of a pair arrives.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   i_clr    in   discard any half-formed pair (collection disabled)
//   i_vld    in   i_bit carries a raw bit this cycle
//   i_bit    in   raw bit
//   bit_out  out  extracted bit (meaningful when bit_vld=1)
//   bit_vld  out  bit_out is an extracted bit this cycle
// ---------------------------------------------------------------------------
module trng_vn_debias (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_vld,
    input  logic i_bit,
    output logic bit_out,
    output logic bit_vld
);

    logic r_phase;  // 1: first bit of a pair is held in r_first
    logic r_first;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_phase <= 1'b0;
            r_first <= 1'b0;
        end else if (i_vld) begin
            if (!r_phase) begin
                r_first <= i_bit;
            end
            r_phase <= ~r_phase;
        end
    end

    // Pair 10 -> 1 and pair 01 -> 0: the output is simply the first bit.
    assign bit_vld = i_vld && r_phase && (r_first != i_bit);
    assign bit_out = r_first;

endmodule

// File: rtl/trng_collector.sv
// ---------------------------------------------------------------------------
// trng_collector
//   Samples one raw TRNG bit per clock while enabled, runs a continuous
//   repetition-count health test on the raw bits, deserializes accepted bits
//   into W-bit words (first bit lands in data[W-1]) and delivers them over a
//   valid/ready handshake. A health failure is sticky until rst.
//
//   Handshake: a word is transferred when valid && ready at a rising edge.
//   Once valid=1, data holds until that transfer; valid is a register and
//   never depends combinationally on ready.
//
//   Optional build macro TRNG_VN_DEBIAS_EN inserts a von Neumann extractor
//   between raw sampling and deserialization. The health test always sees
//   raw bits.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   collection enable
//   rand_in      in   raw TRNG bit (already registered in clk domain)
//   ready        in   downstream accepts data this cycle
//   data         out  collected word [W-1:0]
//   valid        out  data holds an unconsumed word
//   fail         out  sticky health-test failure
//   o_dbg_state  out  current FSM state (trng_state_e encoding)
// ---------------------------------------------------------------------------
module trng_collector
    import trng_pkg::*;
#(
    parameter int W        = TRNG_W,
    parameter int LOGW     = TRNG_LOGW,
    parameter int RC_LIMIT = TRNG_RC_LIMIT,
    parameter int LOG_RC   = TRNG_LOG_RC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         rand_in,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         fail,
    output logic [1:0]   o_dbg_state
);

    localparam logic [LOGW-1:0]   FILL_LAST = LOGW'(W - 1);
    localparam logic [LOG_RC-1:0] RC_LIM_C  = LOG_RC'(RC_LIMIT);

    trng_state_e r_state;
    trng_state_e w_state_nxt;

    // Raw sampling stage: bit captured at edge t is processed before edge t+1.
    logic r_smp_vld;
    logic r_smp_bit;

    // Health test
    logic              r_prev;
    logic [LOG_RC-1:0] r_rc;
    logic [LOG_RC-1:0] w_rc_nxt;
    logic              w_hfail;

    // Deserializer; a complete word that cannot be delivered waits in r_sreg.
    logic [W-1:0]    r_sreg;
    logic [LOGW-1:0] r_fill;
    logic            r_pend;
    logic [W-1:0]    w_word;

    // Output
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_fail;

    logic w_proc;     // a sampled raw bit is processed this cycle
    logic w_acc_vld;  // an accepted bit is offered to the deserializer
    logic w_acc_bit;
    logic w_take;     // accepted bit is collected (not dropped)
    logic w_done;     // collected bit completes a word
    logic w_free;     // output register can take a word this cycle

`ifdef TRNG_VN_DEBIAS_EN
    logic w_vn_bit;
    logic w_vn_vld;

    trng_vn_debias u_debias (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!en),
        .i_vld   (w_proc),
        .i_bit   (r_smp_bit),
        .bit_out (w_vn_bit),
        .bit_vld (w_vn_vld)
    );

    assign w_acc_vld = w_vn_vld;
    assign w_acc_bit = w_vn_bit;
`else
    assign w_acc_vld = w_proc;
    assign w_acc_bit = r_smp_bit;
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_proc      = r_smp_vld && en && (r_state == ST_FILL);
        // rc==0 marks the first bit since entering ST_FILL.
        w_rc_nxt    = ((r_rc == '0) || (r_smp_bit != r_prev)) ?
                      LOG_RC'(1) : (r_rc + LOG_RC'(1));
        w_hfail     = w_proc && (w_rc_nxt == RC_LIM_C);
        w_take      = w_acc_vld && !r_pend;
        w_word      = {r_sreg[W-2:0], w_acc_bit};
        w_done      = w_take && (r_fill == FILL_LAST);
        w_free      = !r_valid || ready;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_hfail) begin
                    w_state_nxt = ST_FAIL;
                end else if (!en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Raw sampling
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_smp_vld <= 1'b0;
            r_smp_bit <= 1'b0;
        end else begin
            r_smp_vld <= (r_state == ST_FILL);
            r_smp_bit <= rand_in;
        end
    end

    // -----------------------------------------------------------------------
    // Repetition-count health test on raw bits
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_rc   <= '0;
            r_prev <= 1'b0;
        end else if (w_proc) begin
            r_rc   <= w_rc_nxt;
            r_prev <= r_smp_bit;
        end
    end

    // -----------------------------------------------------------------------
    // Deserializer, pending word and output handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg  <= '0;
            r_fill  <= '0;
            r_pend  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fail  <= 1'b0;
        end else if (w_hfail) begin
            // Failure wins over any transfer or consumption this cycle.
            r_fail  <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pend  <= 1'b0;
            r_fill  <= '0;
        end else begin
            if (!en) begin
                // Drop the partial word; a pending complete word survives.
                r_fill <= '0;
                if (!r_pend) begin
                    r_sreg <= '0;
                end
            end else if (w_take) begin
                r_sreg <= w_word;
                r_fill <= w_done ? '0 : (r_fill + LOGW'(1));
            end

            if (r_pend && w_free) begin
                r_data  <= r_sreg;
                r_valid <= 1'b1;
                r_pend  <= 1'b0;
            end else if (w_done) begin
                if (w_free) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_pend  <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign fail        = r_fail;
    assign o_dbg_state = r_state;

endmodule
